// File: rtl/registrador_saida_fifo_if.sv
// Producer/consumer bundle for registrador_saida_fifo: bus load side plus display handshake.
// OUT_OVERFLOW_FLAG_EN adds the sticky ovf status line.
interface registrador_saida_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             Lo;
  logic [WIDTH-1:0] entrada;
  logic             saida_ready;
  logic             saida_valid;
  logic [WIDTH-1:0] saida;
  logic [AW+1:0]    nivel;
  logic             vazio;
  logic             cheio;
`ifdef OUT_OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output Lo, entrada, saida_ready,
`ifdef OUT_OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  saida_valid, saida, nivel, vazio, cheio
  );

  modport slave (
    input  Lo, entrada, saida_ready,
`ifdef OUT_OVERFLOW_FLAG_EN
    output ovf,
`endif
    output saida_valid, saida, nivel, vazio, cheio
  );
endinterface

// File: rtl/registrador_saida_fifo.sv
// SAP-1 style output register fronted by a DEPTH-entry FIFO; saida holds the last word shown.
// Optional sticky overflow flag under OUT_OVERFLOW_FLAG_EN.
module registrador_saida_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                   CLK,
  input logic                   CLR_n,
  registrador_saida_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             valid_q, valid_d;
  logic [AW+1:0]    nivel;
  logic             cheio, pop, push, fifo_wr, fifo_rd;

  assign nivel = {1'b0, cnt_q} + {{(AW+1){1'b0}}, valid_q};
  assign cheio = (nivel == (AW+2)'(DEPTH + 1));
  assign pop   = valid_q & bus.saida_ready;
  assign push  = bus.Lo & (~cheio | pop);

  // A pushed word goes straight to saida only when the FIFO is empty, so order is kept.
  always_comb begin
    saida_d = saida_q;
    valid_d = valid_q;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    if (valid_q & ~pop) begin
      fifo_wr = push;
    end else if (cnt_q != '0) begin
      fifo_rd = 1'b1;
      fifo_wr = push;
      saida_d = mem_q[rd_q];
      valid_d = 1'b1;
    end else if (push) begin
      saida_d = bus.entrada;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  assign wr_d  = wr_q + AW'(fifo_wr);
  assign rd_d  = rd_q + AW'(fifo_rd);
  assign cnt_d = cnt_q + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      saida_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      saida_q <= saida_d;
      valid_q <= valid_d;
    end
  end

  // Storage is intentionally left uninitialised by reset.
  always_ff @(posedge CLK) begin
    if (fifo_wr) mem_q[wr_q] <= bus.entrada;
  end

`ifdef OUT_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | (bus.Lo & cheio & ~pop);
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`endif

  assign bus.saida       = saida_q;
  assign bus.saida_valid = valid_q;
  assign bus.nivel       = nivel;
  assign bus.vazio       = (nivel == '0);
  assign bus.cheio       = cheio;
endmodule

// File: tb/tb_registrador_saida_fifo.sv
// Scoreboard bench: driver pushes accepted words into a queue, monitor checks order/level/hold.
// Define OUT_OVERFLOW_FLAG_EN to also check the ovf flag.
module tb_registrador_saida_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MAXL  = DEPTH + 1;

  logic CLK = 1'b0;
  logic CLR_n = 1'b1;
  always #5 CLK = ~CLK;

  registrador_saida_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  registrador_saida_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .CLR_n(CLR_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  int lvl = 0, lvl_nx = 0;
  logic [WIDTH-1:0] hold = '0;
  logic [WIDTH-1:0] exp_q[$];
`ifdef OUT_OVERFLOW_FLAG_EN
  bit ovf_m = 1'b0, ovf_nx = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Model: pending words form a queue of at most DEPTH+1; head is what saida shows.
  task automatic cyc(input bit lo, input logic [WIDTH-1:0] d, input bit rdy);
    bit p, u;
    @(posedge CLK); #1;
    lvl = lvl_nx;
`ifdef OUT_OVERFLOW_FLAG_EN
    ovf_m = ovf_nx;
`endif
    bus.Lo = lo; bus.entrada = d; bus.saida_ready = rdy;
    p = (lvl > 0) && rdy;
    u = lo && ((lvl < MAXL) || p);
    if (u) exp_q.push_back(d);
`ifdef OUT_OVERFLOW_FLAG_EN
    if (lo && lvl == MAXL && !p) ovf_nx = 1'b1;
`endif
    lvl_nx = lvl + int'(u) - int'(p);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #3;
    run = 1'b0;
    CLR_n = 1'b0;
    #1;
    chk("rst_saida", bus.saida, 0);
    chk("rst_valid", bus.saida_valid, 0);
    chk("rst_nivel", bus.nivel, 0);
    chk("rst_vazio", bus.vazio, 1);
    chk("rst_cheio", bus.cheio, 0);
`ifdef OUT_OVERFLOW_FLAG_EN
    chk("rst_ovf", bus.ovf, 0);
    ovf_m = 1'b0; ovf_nx = 1'b0;
`endif
    bus.Lo = 1'b0; bus.saida_ready = 1'b0; bus.entrada = '0;
    lvl = 0; lvl_nx = 0; hold = '0;
    exp_q.delete();
    @(negedge CLK);
    CLR_n = 1'b1;
    run = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && lvl_nx > 0; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (run) begin
      chk("nivel", bus.nivel, lvl);
      chk("vazio", bus.vazio, int'(lvl == 0));
      chk("cheio", bus.cheio, int'(lvl == MAXL));
      chk("valid", bus.saida_valid, int'(lvl > 0));
`ifdef OUT_OVERFLOW_FLAG_EN
      chk("ovf", bus.ovf, ovf_m);
`endif
      if (lvl > 0) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          chk("saida", bus.saida, exp_q[0]);
          if (bus.saida_ready) hold = exp_q.pop_front();
        end
      end else begin
        chk("hold", bus.saida, hold);
      end
    end
  end

  initial begin
    int n;
    bus.Lo = 1'b0; bus.entrada = '0; bus.saida_ready = 1'b0;
    apply_reset();

    // single word, then display hold after consumption
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    // fill to DEPTH+1, drop one, drain
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, '0, 1'b0);
    drain();

    // full with simultaneous push and pop
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b0, '0, 1'b0);
    drain();

    // mid-transfer reset
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0);
    apply_reset();

    // 20-word stream with ready toggling; producer honours cheio
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      bit rdy, lo;
      rdy = c[0];
      lo = (lvl_nx < MAXL) || (lvl_nx > 0 && rdy);
      if (lo) n++;
      cyc(lo, 8'(8'h20 + n), rdy);
    end
    drain();

    // random mix
    for (int c = 0; c < 400; c++)
      cyc(1'($urandom % 2), 8'($urandom), ($urandom % 3) != 0);
    drain();
    apply_reset();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
